uart_tx_par_gen: RTL and testbench

Parametrised parity generator for the UART transmit path. Accepts a data word of configurable width and computes the parity bit iteratively, CHUNK_W bits per cycle, so wide words close timing at high CLK rates. Supports even, odd, mark and space parity. Uses a DATA_VALID/BUSY/PAR_DONE handshake. Sits between the Tx data register and the Tx frame serializer.

---
 rtl/uart_tx_par_gen.sv | 134 +++++++++++++
 tb/tb_uart_tx_par_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_par_gen.sv
// uart_tx_par_gen: iterative parity generator for the UART transmit path.
// The data word is folded CHUNK_W bits per cycle into a 1-bit XOR accumulator,
// so wide words do not need a single deep XOR tree.
// The result is then mapped to even, odd, mark or space parity.
// Optional feature macro: UART_TX_PAR_ERR_INJ_EN adds an ERR_INJ input.
// When set at acceptance, ERR_INJ inverts the final parity bit of that word.
module uart_tx_par_gen #(
  parameter int DATA_W  = 8,
  parameter int CHUNK_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic [1:0]        PAR_TYP,
`ifdef UART_TX_PAR_ERR_INJ_EN
  input  logic              ERR_INJ,
`endif
  output logic              Parity_Bit,
  output logic              PAR_DONE,
  output logic              BUSY
);

  localparam int NCH   = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NCH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              acc_q, acc_d;
  logic              acc_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
`ifdef UART_TX_PAR_ERR_INJ_EN
  logic              inj_q, inj_d;
`endif

  // Map the raw XOR of the word onto the selected parity type.
  function automatic logic par_sel(input logic acc, input logic [1:0] typ);
    logic r;
    case (typ)
      2'b00:   r = acc;
      2'b01:   r = ~acc;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Running XOR including the chunk currently at the bottom of the shift register.
  assign acc_next = acc_q ^ (^shreg_q[CHUNK_W-1:0]);

  // Next-state, datapath and output decode; every target defaulted to hold.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    par_d   = par_q;
    done_d  = 1'b0;
`ifdef UART_TX_PAR_ERR_INJ_EN
    inj_d   = inj_q;
`endif
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          shreg_d = P_DATA;
          mode_d  = PAR_TYP;
          acc_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = CALC;
`ifdef UART_TX_PAR_ERR_INJ_EN
          inj_d   = ERR_INJ;
`endif
        end
      end
      CALC: begin
        acc_d   = acc_next;
        shreg_d = shreg_q >> CHUNK_W;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
`ifdef UART_TX_PAR_ERR_INJ_EN
          par_d = par_sel(acc_next, mode_q) ^ inj_q;
`else
          par_d = par_sel(acc_next, mode_q);
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PAR_ERR_INJ_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      done_q  <= done_d;
`ifdef UART_TX_PAR_ERR_INJ_EN
      inj_q   <= inj_d;
`endif
    end
  end

  assign Parity_Bit = par_q;
  assign PAR_DONE   = done_q;
  assign BUSY       = (state_q == CALC);

endmodule

// File: tb/tb_uart_tx_par_gen.sv
// Testbench for uart_tx_par_gen: a DATA_W=8/CHUNK_W=2 instance and a DATA_W=8/CHUNK_W=3
// instance, driven with directed and random words and checked against a parity model.
module tb_uart_tx_par_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic [1:0] PAR_TYP = 2'b00;
  logic       Parity_Bit, PAR_DONE, BUSY;
  logic [7:0] pd3 = 8'h00;
  logic       dv3 = 1'b0;
  logic [1:0] pt3 = 2'b00;
  logic       par3, done3, busy3;
`ifdef UART_TX_PAR_ERR_INJ_EN
  logic       ERR_INJ = 1'b0;
  logic       inj3 = 1'b0;
  logic       inj_req = 1'b0;
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_par_gen #(.DATA_W(8), .CHUNK_W(2)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_TYP(PAR_TYP),
`ifdef UART_TX_PAR_ERR_INJ_EN
    .ERR_INJ(ERR_INJ),
`endif
    .Parity_Bit(Parity_Bit), .PAR_DONE(PAR_DONE), .BUSY(BUSY)
  );

  uart_tx_par_gen #(.DATA_W(8), .CHUNK_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .P_DATA(pd3), .DATA_VALID(dv3), .PAR_TYP(pt3),
`ifdef UART_TX_PAR_ERR_INJ_EN
    .ERR_INJ(inj3),
`endif
    .Parity_Bit(par3), .PAR_DONE(done3), .BUSY(busy3)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: parity from the population count of the word, then the mode rule.
  function automatic logic exp_par(input logic [7:0] d, input logic [1:0] t, input logic inj);
    logic r;
    int ones;
    ones = $countones(d);
    case (t)
      2'b00:   r = (ones % 2) == 1;
      2'b01:   r = (ones % 2) == 0;
      2'b10:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r ^ (inj & ERR_ON);
  endfunction

  function automatic logic cur_par(input int sel);
    return (sel == 0) ? Parity_Bit : par3;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel == 0) ? PAR_DONE : done3;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? BUSY : busy3;
  endfunction

  // Present one word, scramble the inputs after acceptance, and wait (bounded) for PAR_DONE.
  task automatic run_word(input int sel, input logic [7:0] d, input logic [1:0] t,
                          output logic par, output int lat, output logic stable,
                          output logic busy_ok);
    logic p0;
    p0 = cur_par(sel);
    if (sel == 0) begin
      P_DATA = d; PAR_TYP = t; DATA_VALID = 1'b1;
`ifdef UART_TX_PAR_ERR_INJ_EN
      ERR_INJ = inj_req;
`endif
    end else begin
      pd3 = d; pt3 = t; dv3 = 1'b1;
    end
    tick();
    if (sel == 0) begin
      DATA_VALID = 1'b0; P_DATA = 8'($urandom); PAR_TYP = 2'($urandom);
`ifdef UART_TX_PAR_ERR_INJ_EN
      ERR_INJ = 1'($urandom);
`endif
    end else begin
      dv3 = 1'b0; pd3 = 8'($urandom); pt3 = 2'($urandom);
    end
    lat = 0; stable = 1'b1; busy_ok = 1'b1;
    while (cur_done(sel) !== 1'b1 && lat < 20) begin
      if (cur_par(sel) !== p0) stable = 1'b0;
      if (cur_busy(sel) !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    par = cur_par(sel);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    total++; if (Parity_Bit !== 1'b0) begin bad++; $display("FAIL reset_par: got %b want 0", Parity_Bit); end
    total++; if (PAR_DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", PAR_DONE); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (busy3 !== 1'b0 || done3 !== 1'b0 || par3 !== 1'b0) begin
      bad++; $display("FAIL reset_dut3: got busy=%b done=%b par=%b want 0 0 0", busy3, done3, par3);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic par, st, bok;
    int lat;
    logic [1:0] typs [2];
    typs[0] = 2'b00; typs[1] = 2'b01;
    foreach (typs[i]) begin
      run_word(0, 8'hA5, typs[i], par, lat, st, bok);
      total++; if (par !== exp_par(8'hA5, typs[i], 1'b0)) begin
        bad++; $display("FAIL basic_par typ=%0d: got %b want %b", typs[i], par, exp_par(8'hA5, typs[i], 1'b0));
      end
      total++; if (lat !== 4) begin bad++; $display("FAIL basic_lat: got %0d want 4", lat); end
      total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy_calc: got %b want 1", bok); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b want 0", BUSY); end
      tick();
      total++; if (PAR_DONE !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got %b want 0", PAR_DONE); end
    end
  endtask

  task automatic test_modes();
    logic par, st, bok;
    int lat;
    for (int m = 0; m < 4; m++) begin
      run_word(0, 8'h07, 2'(m), par, lat, st, bok);
      total++; if (par !== exp_par(8'h07, 2'(m), 1'b0)) begin
        bad++; $display("FAIL modes_par typ=%0d: got %b want %b", m, par, exp_par(8'h07, 2'(m), 1'b0));
      end
      total++; if (lat !== 4) begin bad++; $display("FAIL modes_lat typ=%0d: got %0d want 4", m, lat); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL modes_hold typ=%0d: got %b want 1", m, st); end
    end
  endtask

  task automatic test_random();
    logic par, st, bok;
    int lat;
    logic [7:0] d;
    logic [1:0] t;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom); t = 2'($urandom);
      run_word(0, d, t, par, lat, st, bok);
      total++; if (par !== exp_par(d, t, 1'b0) || lat !== 4) begin
        bad++; $display("FAIL random d=%h t=%0d: got par=%b lat=%0d want par=%b lat=4", d, t, par, lat, exp_par(d, t, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int tdone [2];
    logic pdone [2];
    logic drop;
    tdone[0] = 0; tdone[1] = 0; pdone[0] = 1'bx; pdone[1] = 1'bx;
    tick();
    P_DATA = 8'h01; PAR_TYP = 2'b00; DATA_VALID = 1'b1;
    tick();
    P_DATA = 8'h03;
    ndone = 0; drop = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (drop) begin DATA_VALID = 1'b0; drop = 1'b0; end
      if (PAR_DONE === 1'b1) begin
        if (ndone < 2) begin tdone[ndone] = c; pdone[ndone] = Parity_Bit; end
        ndone++;
        if (ndone == 1) drop = 1'b1;
      end
    end
    total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", ndone); end
    total++; if (pdone[0] !== exp_par(8'h01, 2'b00, 1'b0)) begin bad++; $display("FAIL b2b_first: got %b want 1", pdone[0]); end
    total++; if (pdone[1] !== exp_par(8'h03, 2'b00, 1'b0)) begin bad++; $display("FAIL b2b_second: got %b want 0", pdone[1]); end
    total++; if (tdone[0] !== 4) begin bad++; $display("FAIL b2b_first_time: got %0d want 4", tdone[0]); end
    total++; if (tdone[1] - tdone[0] !== 5) begin bad++; $display("FAIL b2b_gap: got %0d want 5", tdone[1] - tdone[0]); end
  endtask

  task automatic test_padding();
    logic par, st, bok;
    int lat;
    logic [7:0] d;
    logic [1:0] t;
    run_word(1, 8'h80, 2'b00, par, lat, st, bok);
    total++; if (par !== exp_par(8'h80, 2'b00, 1'b0)) begin bad++; $display("FAIL pad_80: got %b want 1", par); end
    total++; if (lat !== 3) begin bad++; $display("FAIL pad_lat: got %0d want 3", lat); end
    run_word(1, 8'hFF, 2'b00, par, lat, st, bok);
    total++; if (par !== exp_par(8'hFF, 2'b00, 1'b0)) begin bad++; $display("FAIL pad_ff: got %b want 0", par); end
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom); t = 2'($urandom);
      run_word(1, d, t, par, lat, st, bok);
      total++; if (par !== exp_par(d, t, 1'b0) || lat !== 3) begin
        bad++; $display("FAIL pad_random d=%h t=%0d: got par=%b lat=%0d want par=%b lat=3", d, t, par, lat, exp_par(d, t, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic par, st, bok, seen;
    int lat;
    run_word(0, 8'h01, 2'b00, par, lat, st, bok);
    total++; if (par !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %b want 1", par); end
    tick();
    P_DATA = 8'h01; PAR_TYP = 2'b00; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    tick();
    RST = 1'b0; DATA_VALID = 1'b1;
    tick();
    RST = 1'b1; DATA_VALID = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    total++; if (Parity_Bit !== 1'b0) begin bad++; $display("FAIL rstmid_par: got %b want 0", Parity_Bit); end
    total++; if (PAR_DONE !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", PAR_DONE); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (PAR_DONE === 1'b1 || BUSY === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: got %b want 0", seen); end
    run_word(0, 8'h07, 2'b00, par, lat, st, bok);
    total++; if (par !== 1'b1 || lat !== 4) begin bad++; $display("FAIL rstmid_after: got par=%b lat=%0d want par=1 lat=4", par, lat); end
  endtask

`ifdef UART_TX_PAR_ERR_INJ_EN
  task automatic test_err_inj();
    logic par, st, bok;
    int lat;
    inj_req = 1'b1;
    run_word(0, 8'hA5, 2'b00, par, lat, st, bok);
    total++; if (par !== exp_par(8'hA5, 2'b00, 1'b1)) begin bad++; $display("FAIL errinj_on: got %b want 1", par); end
    inj_req = 1'b0;
    run_word(0, 8'hA5, 2'b00, par, lat, st, bok);
    total++; if (par !== exp_par(8'hA5, 2'b00, 1'b0)) begin bad++; $display("FAIL errinj_off: got %b want 0", par); end
    for (int m = 0; m < 4; m++) begin
      inj_req = 1'b1;
      run_word(0, 8'h3C, 2'(m), par, lat, st, bok);
      total++; if (par !== exp_par(8'h3C, 2'(m), 1'b1)) begin bad++; $display("FAIL errinj_mode%0d: got %b want %b", m, par, exp_par(8'h3C, 2'(m), 1'b1)); end
    end
    inj_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_random();
    test_back_to_back();
    test_padding();
    test_reset_mid();
`ifdef UART_TX_PAR_ERR_INJ_EN
    test_err_inj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
